// File: rtl/stack_buffer_pkg.sv
// Shared types and index helpers for stack_buffer.
// Optional build macro: STACK_BUFFER_STICKY_ERR_EN (see stack_buffer.sv).
package stack_buffer_pkg;

    typedef enum logic {
        MODE_LIFO = 1'b0,
        MODE_FIFO = 1'b1
    } mode_e;

    // Modulo increment with explicit compare-and-wrap, valid for any depth.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned depth);
        return (idx + 1 >= depth) ? 32'd0 : idx + 1;
    endfunction

endpackage

// File: rtl/stack_buffer_mem.sv
// Storage array for stack_buffer: one write port, one registered read port.
// Read-before-write on a shared address returns the old word.
module stack_buffer_mem
    import stack_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]           rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Read register holds its value between accepted reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/stack_buffer.sv
// Run-time selectable LIFO/FIFO buffer over circular storage, with flags and error pulses.
// STACK_BUFFER_STICKY_ERR_EN adds err_clr and makes overflow/underflow sticky.
module stack_buffer
    import stack_buffer_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mode,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           data_in,
`ifdef STACK_BUFFER_STICKY_ERR_EN
    input  logic                       err_clr,
`endif
    output logic [WIDTH-1:0]           data_out,
    output logic                       dout_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0] head;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;
    mode_e         mode_q;
    logic          push_ok;
    logic          pop_ok;
    logic          ov_evt;
    logic          un_evt;
    logic [CW-1:0] count_nxt;
    int unsigned   top_slot;

    always_comb begin
        top_slot = 32'(head) + 32'(count);
        if (top_slot >= DEPTH)
            top_slot = top_slot - DEPTH;
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        ov_evt  = push && !push_ok;
        un_evt  = pop && !pop_ok;
        wr_idx  = PW'(top_slot);
        rd_idx  = (top_slot == 0) ? PW'(DEPTH - 1) : PW'(top_slot - 1);
        if (mode_q == MODE_FIFO)
            rd_idx = head;
        else if (pop_ok)
            wr_idx = rd_idx;  // LIFO replace: new word lands in the slot being read
        count_nxt = count + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head        <= '0;
            count       <= '0;
            mode_q      <= MODE_LIFO;
            dout_valid  <= 1'b0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            count       <= count_nxt;
            dout_valid  <= pop_ok;
            empty       <= (count_nxt == '0);
            full        <= (count_nxt == CW'(DEPTH));
            almost_full <= (32'(count_nxt) >= AF_THRESH);
            if (count == '0 && !push)
                mode_q <= mode_e'(mode);
            if (pop_ok && mode_q == MODE_FIFO)
                head <= PW'(wrap_inc(32'(head), DEPTH));
`ifdef STACK_BUFFER_STICKY_ERR_EN
            overflow  <= err_clr ? 1'b0 : (overflow | ov_evt);
            underflow <= err_clr ? 1'b0 : (underflow | un_evt);
`else
            overflow  <= ov_evt;
            underflow <= un_evt;
`endif
        end
    end

    stack_buffer_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push_ok),
        .waddr (wr_idx),
        .wdata (data_in),
        .re    (pop_ok),
        .raddr (rd_idx),
        .rdata (data_out)
    );

endmodule

// File: tb/tb_stack_buffer.sv
// Bench for stack_buffer: DEPTH=16 and DEPTH=5 instances share one stimulus stream,
// each checked every cycle against a list-based model plus literal expectations.
module tb_stack_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] din = '0;

    logic [31:0] a_dout, b_dout;
    logic        a_dv, a_empty, a_full, a_af, a_ov, a_un;
    logic        b_dv, b_empty, b_full, b_af, b_ov, b_un;
    logic [4:0]  a_cnt;
    logic [2:0]  b_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    stack_buffer #(.WIDTH(32), .DEPTH(16)) u16 (
        .clk(clk), .rst(rst), .mode(mode), .push(push), .pop(pop), .data_in(din),
`ifdef STACK_BUFFER_STICKY_ERR_EN
        .err_clr(err_clr),
`endif
        .data_out(a_dout), .dout_valid(a_dv), .count(a_cnt), .empty(a_empty),
        .full(a_full), .almost_full(a_af), .overflow(a_ov), .underflow(a_un)
    );

    stack_buffer #(.WIDTH(32), .DEPTH(5)) u5 (
        .clk(clk), .rst(rst), .mode(mode), .push(push), .pop(pop), .data_in(din),
`ifdef STACK_BUFFER_STICKY_ERR_EN
        .err_clr(err_clr),
`endif
        .data_out(b_dout), .dout_valid(b_dv), .count(b_cnt), .empty(b_empty),
        .full(b_full), .almost_full(b_af), .overflow(b_ov), .underflow(b_un)
    );

    // Model: contents as an ordered list, index 0 = oldest word.
    int          dp [2] = '{16, 5};
    int          afth [2] = '{14, 3};
    logic [31:0] ml [2][16];
    int          mn [2] = '{0, 0};
    logic        mmode [2] = '{1'b0, 1'b0};
    logic [31:0] edout [2] = '{32'd0, 32'd0};
    logic        edv [2] = '{1'b0, 1'b0};
    logic        eov [2] = '{1'b0, 1'b0};
    logic        eun [2] = '{1'b0, 1'b0};
    logic        evo, evu;
    int          n0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                mn[k] = 0; mmode[k] = 1'b0; edout[k] = '0;
                edv[k] = 1'b0; eov[k] = 1'b0; eun[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                evo = 1'b0; evu = 1'b0; edv[k] = 1'b0; n0 = mn[k];
                if (push && pop) begin
                    if (mn[k] == 0) begin
                        ml[k][0] = din; mn[k] = 1; evu = 1'b1;
                    end else begin
                        edv[k] = 1'b1;
                        if (!mmode[k]) begin
                            edout[k] = ml[k][mn[k]-1];
                        end else begin
                            edout[k] = ml[k][0];
                            for (int i = 0; i < mn[k] - 1; i++) ml[k][i] = ml[k][i+1];
                        end
                        ml[k][mn[k]-1] = din;
                    end
                end else if (push) begin
                    if (mn[k] == dp[k]) evo = 1'b1;
                    else begin ml[k][mn[k]] = din; mn[k]++; end
                end else if (pop) begin
                    if (mn[k] == 0) evu = 1'b1;
                    else begin
                        edv[k] = 1'b1;
                        if (!mmode[k]) edout[k] = ml[k][mn[k]-1];
                        else begin
                            edout[k] = ml[k][0];
                            for (int i = 0; i < mn[k] - 1; i++) ml[k][i] = ml[k][i+1];
                        end
                        mn[k]--;
                    end
                end
                if (n0 == 0 && !push) mmode[k] = mode;
`ifdef STACK_BUFFER_STICKY_ERR_EN
                eov[k] = err_clr ? 1'b0 : (eov[k] | evo);
                eun[k] = err_clr ? 1'b0 : (eun[k] | evu);
`else
                eov[k] = evo;
                eun[k] = evu;
`endif
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("d16 data_out",    a_dout,      edout[0]);
            chk("d16 dout_valid",  32'(a_dv),   32'(edv[0]));
            chk("d16 count",       32'(a_cnt),  32'(mn[0]));
            chk("d16 empty",       32'(a_empty), 32'(mn[0] == 0));
            chk("d16 full",        32'(a_full), 32'(mn[0] == dp[0]));
            chk("d16 almost_full", 32'(a_af),   32'(mn[0] >= afth[0]));
            chk("d16 overflow",    32'(a_ov),   32'(eov[0]));
            chk("d16 underflow",   32'(a_un),   32'(eun[0]));
            chk("d5 data_out",     b_dout,      edout[1]);
            chk("d5 dout_valid",   32'(b_dv),   32'(edv[1]));
            chk("d5 count",        32'(b_cnt),  32'(mn[1]));
            chk("d5 empty",        32'(b_empty), 32'(mn[1] == 0));
            chk("d5 full",         32'(b_full), 32'(mn[1] == dp[1]));
            chk("d5 almost_full",  32'(b_af),   32'(mn[1] >= afth[1]));
            chk("d5 overflow",     32'(b_ov),   32'(eov[1]));
            chk("d5 underflow",    32'(b_un),   32'(eun[1]));
        end
    end

    task automatic cyc(input logic p, input logic q, input logic [31:0] d);
        push = p; pop = q; din = d;
        @(posedge clk);
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0);
    endtask

    task automatic clr_err();
        err_clr = 1'b1;
        cyc(1'b0, 1'b0, 32'd0);
        err_clr = 1'b0;
    endtask

    logic [31:0] exp5 [5];

    initial begin
        exp5 = '{32'hA2, 32'hA3, 32'hA4, 32'hB0, 32'hB1};
        repeat (2) @(negedge clk);
        chk("reset count",      32'(a_cnt), 32'd0);
        chk("reset empty",      32'(a_empty), 32'd1);
        chk("reset dout_valid", 32'(a_dv), 32'd0);
        chk("reset data_out",   a_dout, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // LIFO order
        cyc(1, 0, 32'h11); cyc(1, 0, 32'h22); cyc(1, 0, 32'h33);
        cyc(0, 1, 0); chk("lifo pop1", a_dout, 32'h33); chk("lifo pop1 valid", 32'(a_dv), 32'd1);
        cyc(0, 1, 0); chk("lifo pop2", a_dout, 32'h22);
        cyc(0, 1, 0); chk("lifo pop3", a_dout, 32'h11);
        idle(1);
        chk("lifo drained empty", 32'(a_empty), 32'd1);
        chk("lifo drained count", 32'(a_cnt), 32'd0);
        chk("lifo valid drops", 32'(a_dv), 32'd0);

        // Simultaneous push+pop in LIFO
        cyc(1, 0, 32'h11); cyc(1, 0, 32'h22); cyc(1, 0, 32'h33);
        cyc(1, 1, 32'h44);
        chk("lifo replace out", a_dout, 32'h33);
        chk("lifo replace count", 32'(a_cnt), 32'd3);
        cyc(0, 1, 0); chk("lifo replace top", a_dout, 32'h44);
        cyc(0, 1, 0); cyc(0, 1, 0);

        // Mode lock while non-empty, then latch FIFO when idle and empty
        cyc(1, 0, 32'h1); cyc(1, 0, 32'h2);
        mode = 1'b1;
        cyc(0, 1, 0); chk("mode lock pop1", a_dout, 32'h2);
        cyc(0, 1, 0); chk("mode lock pop2", a_dout, 32'h1);
        idle(1);

        // FIFO wrap on the DEPTH=5 instance
        for (int i = 0; i < 5; i++) cyc(1, 0, 32'hA0 + 32'(i));
        chk("d5 full after 5", 32'(b_full), 32'd1);
        cyc(0, 1, 0); chk("d5 fifo A0", b_dout, 32'hA0);
        cyc(0, 1, 0); chk("d5 fifo A1", b_dout, 32'hA1);
        cyc(1, 0, 32'hB0); cyc(1, 0, 32'hB1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0);
            chk("d5 fifo wrap order", b_dout, exp5[i]);
        end
        chk("d5 drained empty", 32'(b_empty), 32'd1);

        // Full/empty boundaries on the DEPTH=16 instance
        for (int i = 0; i < 17; i++) cyc(1, 0, 32'h100 + 32'(i));
        chk("d16 overflow on 17th", 32'(a_ov), 32'd1);
        chk("d16 count stays 16", 32'(a_cnt), 32'd16);
        clr_err();
        cyc(1, 1, 32'h1FF);
        chk("fifo full push+pop count", 32'(a_cnt), 32'd16);
        chk("fifo full push+pop no overflow", 32'(a_ov), 32'd0);
        chk("fifo full push+pop out", a_dout, 32'h100);
        for (int i = 0; i < 17; i++) begin
            cyc(0, 1, 0);
            if (i == 15) chk("d16 last word", a_dout, 32'h1FF);
        end
        chk("d16 underflow on 17th", 32'(a_un), 32'd1);
        chk("d16 no valid on underflow", 32'(a_dv), 32'd0);
        clr_err();

        // Asynchronous reset mid-stream
        for (int i = 0; i < 8; i++) cyc(1, 0, 32'h200 + 32'(i));
        cyc(0, 1, 0);
        chk("pre-reset count", 32'(a_cnt), 32'd7);
        #2 rst = 1'b1;
        #1;
        chk("async reset count", 32'(a_cnt), 32'd0);
        chk("async reset empty", 32'(a_empty), 32'd1);
        chk("async reset valid", 32'(a_dv), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 1, 0);
        chk("post-reset underflow", 32'(a_un), 32'd1);
        chk("post-reset no valid", 32'(a_dv), 32'd0);
        idle(1);
`ifdef STACK_BUFFER_STICKY_ERR_EN
        chk("sticky underflow held", 32'(a_un), 32'd1);
        clr_err();
        chk("sticky underflow cleared", 32'(a_un), 32'd0);
`endif
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
